// File: rtl/mips_fetch_pkg.sv
// mips_fetch_pkg: MIPS32 instruction field layout and decode helpers
package mips_fetch_pkg;
  localparam int XLEN_FIXED = 32;
  localparam int OPCODE_MSB = 31, OPCODE_LSB = 26;
  localparam int RS_MSB = 25, RS_LSB = 21;
  localparam int RT_MSB = 20, RT_LSB = 16;
  localparam int RD_MSB = 15, RD_LSB = 11;
  localparam int SHAMT_MSB = 10, SHAMT_LSB = 6;
  localparam int FUNCT_MSB = 5, FUNCT_LSB = 0;
  localparam int IMM_MSB = 15, IMM_LSB = 0;
  localparam int TARGET_MSB = 25, TARGET_LSB = 0;
  typedef struct packed {
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [15:0] imm;
    logic [25:0] target;
  } instr_fields_t;
  function automatic instr_fields_t decode_fields(input logic [XLEN_FIXED-1:0] instr);
    instr_fields_t f;
    f.opcode = instr[OPCODE_MSB:OPCODE_LSB];
    f.rs     = instr[RS_MSB:RS_LSB];
    f.rt     = instr[RT_MSB:RT_LSB];
    f.rd     = instr[RD_MSB:RD_LSB];
    f.shamt  = instr[SHAMT_MSB:SHAMT_LSB];
    f.funct  = instr[FUNCT_MSB:FUNCT_LSB];
    f.imm    = instr[IMM_MSB:IMM_LSB];
    f.target = instr[TARGET_MSB:TARGET_LSB];
    return f;
  endfunction
  function automatic logic [XLEN_FIXED-1:0] sign_extend16(input logic [15:0] v);
    return {{(XLEN_FIXED-16){v[15]}}, v};
  endfunction
endpackage

// File: rtl/fetch_queue_if.sv
// fetch_queue_if: instruction memory, redirect and decode-side signals of the fetch front end
interface fetch_queue_if #(parameter int XLEN = 32);
  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] imem_rdata;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_instr;
  logic [5:0]      out_opcode;
  logic [4:0]      out_rs;
  logic [4:0]      out_rt;
  logic [4:0]      out_rd;
  logic [4:0]      out_shamt;
  logic [5:0]      out_funct;
  logic [15:0]     out_imm;
  logic [25:0]     out_target;
  logic [XLEN-1:0] out_imm_sext;
  modport master (
    output imem_req, imem_addr, out_valid, out_pc, out_instr, out_opcode, out_rs, out_rt,
           out_rd, out_shamt, out_funct, out_imm, out_target, out_imm_sext,
    input  imem_rdata, redirect_valid, redirect_pc, out_ready
  );
  modport slave (
    input  imem_req, imem_addr, out_valid, out_pc, out_instr, out_opcode, out_rs, out_rt,
           out_rd, out_shamt, out_funct, out_imm, out_target, out_imm_sext,
    output imem_rdata, redirect_valid, redirect_pc, out_ready
  );
endinterface

// File: rtl/fetch_fifo.sv
// fetch_fifo: synchronous FIFO with occupancy count, flush and simultaneous push/pop
module fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             dout,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  assign dout = mem[rd_ptr];
  // storage is cleared on reset so the head reads as zero; flush only rewinds pointers
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) mem[wr_ptr] <= din;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + ($clog2(DEPTH)+1)'(push) - ($clog2(DEPTH)+1)'(pop);
    end
  end
  // the fetch credit scheme must never let a push land on a full queue
  always_ff @(posedge clk) begin
    if (!rst && !flush) assert (!(push && !pop && count == ($clog2(DEPTH)+1)'(DEPTH)));
  end
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: sequential PC generation, credit-limited imem fetch and decoded instruction queue
module fetch_queue
  import mips_fetch_pkg::*;
#(
  parameter int          XLEN     = 32,
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic          clk,
  input logic          rst,
  fetch_queue_if.master bus
);
  logic [XLEN-1:0]        fetch_pc, inflight_pc, head_pc, head_instr;
  logic                   inflight, req, push, pop;
  logic [$clog2(DEPTH):0] count;
  instr_fields_t          f;
  assign req  = !rst && !bus.redirect_valid && (int'(count) + int'(inflight) < DEPTH);
  assign push = inflight && !bus.redirect_valid;
  assign pop  = bus.out_valid && bus.out_ready && !bus.redirect_valid;
  assign bus.imem_req  = req;
  assign bus.imem_addr = fetch_pc;
  // PC advances on every issued request; a redirect drops any in-flight response
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= '0;
    end else if (bus.redirect_valid) begin
      fetch_pc <= bus.redirect_pc & ~XLEN'(3);
      inflight <= 1'b0;
    end else begin
      if (req) fetch_pc <= fetch_pc + XLEN'(4);
      if (req) inflight_pc <= fetch_pc;
      inflight <= req;
    end
  end
  fetch_fifo #(.DEPTH(DEPTH), .W(2*XLEN)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (bus.redirect_valid),
    .push  (push),
    .pop   (pop),
    .din   ({inflight_pc, bus.imem_rdata}),
    .dout  ({head_pc, head_instr}),
    .count (count)
  );
  assign f                = decode_fields(head_instr);
  assign bus.out_valid    = count != '0;
  assign bus.out_pc       = head_pc;
  assign bus.out_instr    = head_instr;
  assign bus.out_opcode   = f.opcode;
  assign bus.out_rs       = f.rs;
  assign bus.out_rt       = f.rt;
  assign bus.out_rd       = f.rd;
  assign bus.out_shamt    = f.shamt;
  assign bus.out_funct    = f.funct;
  assign bus.out_imm      = f.imm;
  assign bus.out_target   = f.target;
  assign bus.out_imm_sext = sign_extend16(f.imm);
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed checks of fetch latency, decode, backpressure, redirect, wrap and reset
module tb_fetch_queue;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int errors = 0;
  int nreq;
  fetch_queue_if #(.XLEN(32)) ifc ();
  fetch_queue #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0)) dut (.clk(clk), .rst(rst), .bus(ifc));
  // free-running clock
  always #5 clk = ~clk;
  function automatic logic [31:0] imem_word(input logic [31:0] a);
    return a == 32'h200 ? 32'h2128_FFFC : a == 32'h204 ? 32'h012A_4020 : a ^ 32'hA5A5_0000;
  endfunction
  // synchronous instruction memory: word appears the cycle after the request
  always @(posedge clk) if (ifc.imem_req) ifc.imem_rdata <= imem_word(ifc.imem_addr);
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask
  initial begin
    rst = 1'b1;
    ifc.out_ready = 1'b0;
    ifc.redirect_valid = 1'b0;
    ifc.redirect_pc = '0;
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(ifc.out_valid), 0);
    chk("rst_req", 32'(ifc.imem_req), 0);
    chk("rst_pc", ifc.out_pc, 0);
    chk("rst_instr", ifc.out_instr, 0);
    chk("rst_sext", ifc.out_imm_sext, 0);
    chk("rst_target", 32'(ifc.out_target), 0);
    rst = 1'b0;
    ifc.out_ready = 1'b1;
    #1;
    chk("first_req", 32'(ifc.imem_req), 1);
    chk("first_addr", ifc.imem_addr, 0);
    @(negedge clk);
    chk("lat_valid", 32'(ifc.out_valid), 0);
    chk("second_addr", ifc.imem_addr, 4);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("stream_valid", 32'(ifc.out_valid), 1);
      chk("stream_pc", ifc.out_pc, 32'(4*i));
      chk("stream_instr", ifc.out_instr, 32'(4*i) ^ 32'hA5A5_0000);
    end
    ifc.redirect_valid = 1'b1;
    ifc.redirect_pc = 32'h200;
    #1;
    chk("redir_noreq", 32'(ifc.imem_req), 0);
    @(negedge clk);
    ifc.redirect_valid = 1'b0;
    #1;
    chk("redir_valid", 32'(ifc.out_valid), 0);
    chk("redir_req", 32'(ifc.imem_req), 1);
    chk("redir_addr", ifc.imem_addr, 32'h200);
    @(negedge clk);
    chk("redir_lat", 32'(ifc.out_valid), 0);
    @(negedge clk);
    chk("addi_pc", ifc.out_pc, 32'h200);
    chk("addi_opcode", 32'(ifc.out_opcode), 32'h08);
    chk("addi_rs", 32'(ifc.out_rs), 9);
    chk("addi_rt", 32'(ifc.out_rt), 8);
    chk("addi_imm", 32'(ifc.out_imm), 32'hFFFC);
    chk("addi_sext", ifc.out_imm_sext, 32'hFFFF_FFFC);
    @(negedge clk);
    chk("rtype_pc", ifc.out_pc, 32'h204);
    chk("rtype_opcode", 32'(ifc.out_opcode), 0);
    chk("rtype_rt", 32'(ifc.out_rt), 10);
    chk("rtype_rd", 32'(ifc.out_rd), 8);
    chk("rtype_shamt", 32'(ifc.out_shamt), 0);
    chk("rtype_funct", 32'(ifc.out_funct), 32'h20);
    ifc.out_ready = 1'b0;
    ifc.redirect_valid = 1'b1;
    ifc.redirect_pc = 32'h0;
    @(negedge clk);
    ifc.redirect_valid = 1'b0;
    nreq = 0;
    for (int k = 0; k < 8; k++) begin
      #1;
      if (ifc.imem_req) begin
        chk("bp_addr", ifc.imem_addr, 32'(4*nreq));
        nreq++;
      end
      if (k >= 2) chk("bp_head", ifc.out_pc, 0);
      if (k < 7) @(negedge clk);
    end
    chk("bp_nreq", 32'(nreq), 4);
    chk("bp_req_low", 32'(ifc.imem_req), 0);
    chk("bp_valid", 32'(ifc.out_valid), 1);
    ifc.out_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      @(negedge clk);
      chk("drain_pc", ifc.out_pc, 32'(4*i));
      chk("drain_instr", ifc.out_instr, 32'(4*i) ^ 32'hA5A5_0000);
      if (i == 1) chk("resume_addr", ifc.imem_addr, 32'h10);
    end
    ifc.out_ready = 1'b0;
    ifc.redirect_valid = 1'b1;
    ifc.redirect_pc = 32'h0;
    @(negedge clk);
    ifc.redirect_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("full_credit_req", 32'(ifc.imem_req), 0);
    ifc.redirect_valid = 1'b1;
    ifc.redirect_pc = 32'h0000_0103;
    @(negedge clk);
    ifc.redirect_valid = 1'b0;
    #1;
    chk("flush_valid", 32'(ifc.out_valid), 0);
    chk("flush_addr", ifc.imem_addr, 32'h100);
    ifc.out_ready = 1'b1;
    @(negedge clk);
    chk("flush_addr2", ifc.imem_addr, 32'h104);
    chk("flush_lat", 32'(ifc.out_valid), 0);
    @(negedge clk);
    chk("flush_head_pc", ifc.out_pc, 32'h100);
    chk("flush_head_instr", ifc.out_instr, 32'hA5A5_0100);
    ifc.redirect_valid = 1'b1;
    ifc.redirect_pc = 32'hFFFF_FFF8;
    @(negedge clk);
    ifc.redirect_valid = 1'b0;
    #1;
    chk("busy_redir_valid", 32'(ifc.out_valid), 0);
    chk("wrap_addr0", ifc.imem_addr, 32'hFFFF_FFF8);
    @(negedge clk);
    chk("wrap_addr1", ifc.imem_addr, 32'hFFFF_FFFC);
    @(negedge clk);
    chk("wrap_addr2", ifc.imem_addr, 32'h0);
    chk("wrap_head0", ifc.out_pc, 32'hFFFF_FFF8);
    chk("wrap_instr0", ifc.out_instr, 32'h5A5A_FFF8);
    @(negedge clk);
    chk("wrap_head1", ifc.out_pc, 32'hFFFF_FFFC);
    @(negedge clk);
    chk("wrap_head2", ifc.out_pc, 32'h0);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_valid", 32'(ifc.out_valid), 0);
    chk("mid_rst_req", 32'(ifc.imem_req), 0);
    chk("mid_rst_pc", ifc.out_pc, 0);
    chk("mid_rst_instr", ifc.out_instr, 0);
    chk("mid_rst_funct", 32'(ifc.out_funct), 0);
    rst = 1'b0;
    #1;
    chk("restart_addr", ifc.imem_addr, 0);
    chk("restart_req", 32'(ifc.imem_req), 1);
    repeat (2) @(negedge clk);
    chk("restart_valid", 32'(ifc.out_valid), 1);
    chk("restart_pc", ifc.out_pc, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised instruction-fetch front end for the Harvard MIPS32 core: generates sequential PCs, issues requests to the synchronous instruction memory, and buffers returned words with their PCs in a DEPTH-entry queue. It presents the queue head to decode with a valid/ready handshake, already split into MIPS fields plus a sign-extended immediate. A redirect input (branch/jump) flushes the queue and any in-flight fetch.

## Interface
- XLEN, 32, instruction/PC width (field split is fixed MIPS32 layout; XLEN other than 32 unsupported)
- DEPTH, 4, queue entries (power of two, ≥2)
- RESET_PC, 32'h0000_0000, first fetch address after reset (word aligned)

- clk  in  1  single clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- imem_req  out  1  fetch request this cycle
- imem_addr  out  XLEN  byte address of request, word aligned
- imem_rdata  in  XLEN  instruction word, valid exactly one cycle after imem_req
- redirect_valid  in  1  flush and restart fetch
- redirect_pc  in  XLEN  new fetch address (bits [1:0] ignored, treated as 0)
- out_valid  out  1  queue head valid
- out_ready  in  1  decode accepts head
- out_pc  out  XLEN  PC of head instruction
- out_instr  out  XLEN  raw head instruction
- out_opcode [31:26] 6, out_rs [25:21] 5, out_rt [20:16] 5, out_rd [15:11] 5, out_shamt [10:6] 5, out_funct [5:0] 6, out_imm [15:0] 16, out_target [25:0] 26 — all out, fields of out_instr
- out_imm_sext  out  XLEN  out_imm sign-extended

## Operation
- State: fetch_pc, queue (pc, instr) ×DEPTH with rd/wr pointers and count (0..DEPTH), inflight flag, inflight_pc.
- imem_req = !rst && !redirect_valid && (count + inflight < DEPTH); imem_addr = fetch_pc.
- On req: fetch_pc += 4 (mod 2^XLEN, wraps silently), inflight ← 1, inflight_pc ← fetch_pc.
- Response cycle (inflight=1, no redirect): push {inflight_pc, imem_rdata}; inflight ← req this cycle.
- Pop when out_valid && out_ready. Push and pop in same cycle allowed at any count; count unchanged.
- Credit rule guarantees push never hits a full queue; overflow is a design error (assert in sim).
- Redirect (highest priority): count ← 0, pointers ← 0, inflight ← 0 (response arriving this cycle discarded), fetch_pc ← {redirect_pc[XLEN-1:2],2'b00}; no req this cycle; pop ignored.
- Decoded outputs are combinational from queue head; don't-care values when out_valid=0 but must not be X after reset (queue storage reset to 0).

## Timing
- Reset: out_valid=0, imem_req=0, fetch_pc=RESET_PC, count=0, inflight=0, all out_* fields 0. Reset mid-operation discards everything identically to redirect.
- First req in first cycle with rst=0, addr=RESET_PC.
- Fetch latency: req at cycle t → rdata at t+1 → out_valid at t+2 (no bypass).
- Redirect at cycle t → first req to redirect_pc at t+1 → out_valid earliest t+3.
- Steady state with out_ready=1: one instruction per cycle.
- out_ready=0: head and all out_* held stable; fetch continues until count+inflight = DEPTH, then imem_req=0.
- Handshake: out_valid never drops without a pop or redirect/reset.

## Structure
- Package mips_fetch_pkg: field position/width localparams (OPCODE_MSB… etc.), instr_fields_t struct, function decode_fields(instr) returning it, and sign_extend16.
- One sub-module: fetch_fifo (parametrised DEPTH × (2·XLEN) sync FIFO with count, flush, push/pop same cycle). Top holds PC, inflight tracking, credit logic, decode.

## Test plan
- Reset then out_ready=1, imem model returns addr^32'hA5A5_0000 → out_pc 0,4,8,… one per cycle from cycle 2; out_instr matches.
- Instruction 32'h2128_FFFC (addi $8,$9,-4) → opcode 0x08, rs 9, rt 8, out_imm 0xFFFC, out_imm_sext 32'hFFFF_FFFC; R-type 32'h012A_4020 → rd 8, funct 0x20, shamt 0.
- out_ready=0 from cycle 0, DEPTH=4 → exactly 4 reqs (PC 0..12), imem_req low afterwards, head stays PC 0; release ready → 0,4,8,12 drained then fetch resumes at 16.
- Redirect to 32'h0000_0103 while queue holds 3 entries and a fetch is in flight → out_valid=0 next cycle, next req addr 0x100, in-flight word never appears.
- Redirect same cycle as out_ready=1 and response arrival → no pop counted, no push; rst asserted mid-stream → all outputs return to reset values next cycle, restart at RESET_PC.
- fetch_pc at 32'hFFFF_FFFC → next req addr 0x0000_0000.
